// File: rtl/wb_copy_master_if.sv
// Wishbone B4 pipelined bus bundle for wb_copy_master.
// The error termination line exists only when WB_COPY_ERR_EN is defined.
interface wb_copy_master_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] adr_o;
    logic [DATA_WIDTH-1:0] dat_o;
    logic [DATA_WIDTH-1:0] dat_i;
    logic                  cyc_o;
    logic                  stb_o;
    logic                  we_o;
    logic                  stall_i;
    logic                  ack_i;
`ifdef WB_COPY_ERR_EN
    logic                  err_i;

    modport master (
        output adr_o, dat_o, cyc_o, stb_o, we_o,
        input  dat_i, stall_i, ack_i, err_i
    );
    modport slave (
        input  adr_o, dat_o, cyc_o, stb_o, we_o,
        output dat_i, stall_i, ack_i, err_i
    );
`else
    modport master (
        output adr_o, dat_o, cyc_o, stb_o, we_o,
        input  dat_i, stall_i, ack_i
    );
    modport slave (
        input  adr_o, dat_o, cyc_o, stb_o, we_o,
        output dat_i, stall_i, ack_i
    );
`endif
endinterface

// File: rtl/wb_copy_master.sv
// DREQ-gated Wishbone B4 pipelined copy master: one read then one write per unit.
// Optional error termination (err_i / sticky err_o) is built when WB_COPY_ERR_EN is defined.
module wb_copy_master #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    LEN_WIDTH    = 16,
    parameter int unsigned           ADDR_STEP    = 1,
    parameter logic [ADDR_WIDTH-1:0] RD_ADDR_INIT = '0,
    parameter logic [ADDR_WIDTH-1:0] WR_ADDR_INIT = '0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  dreq_i,
    input  logic                  cfg_ld_i,
    input  logic [ADDR_WIDTH-1:0] cfg_rd_adr_i,
    input  logic [ADDR_WIDTH-1:0] cfg_wr_adr_i,
    input  logic [LEN_WIDTH-1:0]  cfg_len_i,
    output logic                  busy_o,
    output logic                  done_o,
`ifdef WB_COPY_ERR_EN
    output logic                  err_o,
`endif
    wb_copy_master_if.master      wb
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT
    } state_t;

    state_t                state_q, state_n;
    logic                  cyc_q, cyc_n;
    logic                  stb_q, stb_n;
    logic                  we_q, we_n;
    logic                  busy_q, busy_n;
    logic                  done_q, done_n;
    logic [ADDR_WIDTH-1:0] adr_q, adr_n;
    logic [ADDR_WIDTH-1:0] rd_adr_q, rd_adr_n;
    logic [ADDR_WIDTH-1:0] wr_adr_q, wr_adr_n;
    logic [DATA_WIDTH-1:0] dat_q, dat_n;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_n;
    logic                  fin;
    logic                  abort;
    logic                  rd_phase;
    logic                  term_err;
    logic                  halted_q;
    logic                  halted_n;

`ifdef WB_COPY_ERR_EN
    logic err_q, err_n;
    assign term_err = wb.err_i;
    assign halted_q = err_q;
    assign halted_n = err_n;
`else
    assign term_err = 1'b0;
    assign halted_q = 1'b0;
    assign halted_n = 1'b0;
`endif

    // Address advance wraps modulo 2^ADDR_WIDTH through the truncating add.
    function automatic logic [ADDR_WIDTH-1:0] adr_next(input logic [ADDR_WIDTH-1:0] a);
        return a + ADDR_WIDTH'(ADDR_STEP);
    endfunction

    assign rd_phase = (state_q == RD_REQ) || (state_q == RD_WAIT);

    always_comb begin
        state_n  = state_q;
        cyc_n    = cyc_q;
        stb_n    = stb_q;
        we_n     = we_q;
        adr_n    = adr_q;
        dat_n    = dat_q;
        done_n   = 1'b0;
        rd_adr_n = rd_adr_q;
        wr_adr_n = wr_adr_q;
        cnt_n    = cnt_q;
        fin      = 1'b0;
        abort    = 1'b0;
`ifdef WB_COPY_ERR_EN
        err_n    = err_q;
`endif

        case (state_q)
            IDLE: begin
                if (cfg_ld_i && !busy_q) begin
                    rd_adr_n = cfg_rd_adr_i;
                    wr_adr_n = cfg_wr_adr_i;
                    cnt_n    = cfg_len_i;
`ifdef WB_COPY_ERR_EN
                    err_n    = 1'b0;
`endif
                end
                if ((cnt_q != '0) && dreq_i && !halted_q) begin
                    state_n = RD_REQ;
                    cyc_n   = 1'b1;
                    stb_n   = 1'b1;
                    we_n    = 1'b0;
                    adr_n   = rd_adr_q;
                end
            end
            RD_REQ, WR_REQ: begin
                // Termination is only meaningful on the edge the strobe is taken.
                if (!wb.stall_i) begin
                    if (term_err) begin
                        abort = 1'b1;
                    end else if (wb.ack_i) begin
                        fin = 1'b1;
                    end else begin
                        stb_n   = 1'b0;
                        state_n = (state_q == RD_REQ) ? RD_WAIT : WR_WAIT;
                    end
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (term_err) begin
                    abort = 1'b1;
                end else if (wb.ack_i) begin
                    fin = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cyc_n   = 1'b0;
                stb_n   = 1'b0;
                we_n    = 1'b0;
            end
        endcase

        if (abort) begin
            state_n = IDLE;
            cyc_n   = 1'b0;
            stb_n   = 1'b0;
            we_n    = 1'b0;
`ifdef WB_COPY_ERR_EN
            err_n   = 1'b1;
`endif
        end else if (fin && rd_phase) begin
            dat_n   = wb.dat_i;
            state_n = WR_REQ;
            adr_n   = wr_adr_q;
            we_n    = 1'b1;
            stb_n   = 1'b1;
        end else if (fin) begin
            rd_adr_n = adr_next(rd_adr_q);
            wr_adr_n = adr_next(wr_adr_q);
            cnt_n    = cnt_q - LEN_WIDTH'(1);
            if (cnt_q == LEN_WIDTH'(1)) begin
                done_n  = 1'b1;
                state_n = IDLE;
                cyc_n   = 1'b0;
                stb_n   = 1'b0;
                we_n    = 1'b0;
            end else if (dreq_i) begin
                // Back-to-back unit: keep the bus cycle open.
                state_n = RD_REQ;
                adr_n   = adr_next(rd_adr_q);
                we_n    = 1'b0;
                stb_n   = 1'b1;
            end else begin
                state_n = IDLE;
                cyc_n   = 1'b0;
                stb_n   = 1'b0;
                we_n    = 1'b0;
            end
        end

        // An error-halted block is not busy so that it can be reprogrammed.
        busy_n = cyc_n || ((cnt_n != '0) && !halted_n);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            rd_adr_q <= RD_ADDR_INIT;
            wr_adr_q <= WR_ADDR_INIT;
`ifdef WB_COPY_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_n;
            cyc_q    <= cyc_n;
            stb_q    <= stb_n;
            we_q     <= we_n;
            adr_q    <= adr_n;
            dat_q    <= dat_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
            cnt_q    <= cnt_n;
            rd_adr_q <= rd_adr_n;
            wr_adr_q <= wr_adr_n;
`ifdef WB_COPY_ERR_EN
            err_q    <= err_n;
`endif
        end
    end

    assign wb.cyc_o = cyc_q;
    assign wb.stb_o = stb_q;
    assign wb.we_o  = we_q;
    assign wb.adr_o = adr_q;
    assign wb.dat_o = dat_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
`ifdef WB_COPY_ERR_EN
    assign err_o    = err_q;
`endif

endmodule

// File: tb/tb_wb_copy_master.sv
// Randomised scoreboard bench for wb_copy_master with a behavioural Wishbone slave.
// Error-path scenario is included when WB_COPY_ERR_EN is defined.
module tb_wb_copy_master;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int LW = 16;

    logic          clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          reset_i = 1'b1;
    logic          dreq_i = 1'b0;
    logic          cfg_ld_i = 1'b0;
    logic [AW-1:0] cfg_rd_adr_i = '0;
    logic [AW-1:0] cfg_wr_adr_i = '0;
    logic [LW-1:0] cfg_len_i = '0;
    logic          busy_o;
    logic          done_o;
`ifdef WB_COPY_ERR_EN
    logic          err_o;
`endif

    wb_copy_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb ();

    wb_copy_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .ADDR_STEP(1),
        .RD_ADDR_INIT(16'h0011), .WR_ADDR_INIT(16'h0022)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .dreq_i(dreq_i), .cfg_ld_i(cfg_ld_i),
        .cfg_rd_adr_i(cfg_rd_adr_i), .cfg_wr_adr_i(cfg_wr_adr_i), .cfg_len_i(cfg_len_i),
        .busy_o(busy_o), .done_o(done_o),
`ifdef WB_COPY_ERR_EN
        .err_o(err_o),
`endif
        .wb(wb)
    );

    typedef struct {
        logic [AW-1:0] adr;
        logic          we;
        logic [DW-1:0] dat;
    } acc_t;

    acc_t          exp_q[$];
    int            n_chk = 0, n_fail = 0;
    int            n_acc = 0, n_done = 0, n_stall = 0;
    logic [DW-1:0] key;
    int            ack_lat = 1, stall_prob = 0, force_stall = 0;
    bit            spurious = 0, inject_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave memory contents: a fixed scramble of the address.
    function automatic logic [DW-1:0] rdata(input logic [AW-1:0] a);
        logic [31:0] p;
        p = {16'h0, a} * 32'h0000_9E37 + 32'd17;
        return p[15:0] ^ key;
    endfunction

    // Reference: unit i reads rd+i and writes what it read to wr+i, addresses mod 2^16.
    task automatic push_model(input logic [AW-1:0] rd, input logic [AW-1:0] wr, input int units);
        acc_t e;
        logic [AW-1:0] r, w;
        r = rd;
        w = wr;
        for (int i = 0; i < units; i++) begin
            e.adr = r; e.we = 1'b0; e.dat = '0;
            exp_q.push_back(e);
            e.adr = w; e.we = 1'b1; e.dat = rdata(r);
            exp_q.push_back(e);
            r = r + 16'd1;
            w = w + 16'd1;
        end
    endtask

    task automatic terminate(input logic [AW-1:0] a, input logic we);
`ifdef WB_COPY_ERR_EN
        if (inject_err) begin
            wb.err_i = 1'b1;
            inject_err = 0;
            return;
        end
`endif
        wb.ack_i = 1'b1;
        if (!we) wb.dat_i = rdata(a);
    endtask

    // Behavioural pipelined slave, reacting just after each rising edge.
    initial begin : slave
        bit            pend;
        logic [AW-1:0] padr;
        logic          pwe;
        int            wcnt, lat;
        pend = 0; padr = '0; pwe = 0; wcnt = 0; lat = 0;
        wb.stall_i = 1'b0; wb.ack_i = 1'b0; wb.dat_i = '0;
`ifdef WB_COPY_ERR_EN
        wb.err_i = 1'b0;
`endif
        forever begin
            @(posedge clk_i);
            #1;
            wb.ack_i = 1'b0;
`ifdef WB_COPY_ERR_EN
            wb.err_i = 1'b0;
`endif
            wb.dat_i = 16'($urandom);
            if (reset_i) begin
                pend = 0;
                wb.stall_i = 1'b0;
            end else if (pend) begin
                wb.stall_i = 1'b0;
                if (wcnt == 0) begin
                    terminate(padr, pwe);
                    pend = 0;
                end else begin
                    wcnt--;
                end
            end else if (wb.cyc_o && wb.stb_o) begin
                if (force_stall > 0 || $urandom_range(0, 99) < stall_prob) begin
                    if (force_stall > 0) force_stall--;
                    wb.stall_i = 1'b1;
                    wb.ack_i = spurious && ($urandom_range(0, 2) == 0);
                end else begin
                    wb.stall_i = 1'b0;
                    lat = (ack_lat < 0) ? int'($urandom_range(0, 3)) : ack_lat;
                    if (lat == 0) begin
                        terminate(wb.adr_o, wb.we_o);
                    end else begin
                        pend = 1; padr = wb.adr_o; pwe = wb.we_o; wcnt = lat - 1;
                    end
                end
            end else begin
                wb.stall_i = (stall_prob > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                wb.ack_i = spurious && ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Monitor: every accepted strobe is popped from the scoreboard.
    initial begin : monitor
        acc_t e;
        forever begin
            @(negedge clk_i);
            if (!reset_i) begin
                if (wb.cyc_o && wb.stb_o && wb.stall_i) begin
                    n_stall++;
                    if (exp_q.size() > 0) chk("stall_hold_adr", 32'(wb.adr_o), 32'(exp_q[0].adr));
                end
                if (wb.cyc_o && wb.stb_o && !wb.stall_i) begin
                    n_acc++;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_access: got adr 0x%0h we %0b, expected no access",
                                 wb.adr_o, wb.we_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("acc_adr", 32'(wb.adr_o), 32'(e.adr));
                        chk("acc_we", 32'(wb.we_o), 32'(e.we));
                        if (e.we) chk("wr_data", 32'(wb.dat_o), 32'(e.dat));
                    end
                end
                if (done_o) begin
                    n_done++;
                    chk("done_after_last_write", 32'(exp_q.size()), 32'd0);
                end
            end
        end
    end

    task automatic cfg(input logic [AW-1:0] rd, input logic [AW-1:0] wr, input logic [LW-1:0] len);
        @(negedge clk_i);
        chk("cfg_when_idle", 32'(busy_o), 32'd0);
        cfg_ld_i = 1'b1;
        cfg_rd_adr_i = rd;
        cfg_wr_adr_i = wr;
        cfg_len_i = len;
        @(negedge clk_i);
        cfg_ld_i = 1'b0;
        cfg_rd_adr_i = 16'($urandom);
        cfg_wr_adr_i = 16'($urandom);
        cfg_len_i = 16'($urandom);
    endtask

    task automatic run_xfer(input bit rand_dreq, input bit junk_cfg, output int gaps);
        int  budget;
        bit  seen, ok;
        budget = 0; seen = 0; ok = 0; gaps = 0;
        while (budget < 4000) begin
            @(negedge clk_i);
            budget++;
            if (wb.cyc_o) seen = 1;
            else if (seen && busy_o) gaps++;
            if (exp_q.size() == 0 && !busy_o && !wb.cyc_o) begin
                ok = 1;
                break;
            end
            dreq_i = rand_dreq ? 1'($urandom_range(0, 1)) : 1'b1;
            cfg_ld_i = junk_cfg && busy_o && ($urandom_range(0, 9) == 0);
            cfg_rd_adr_i = 16'($urandom);
            cfg_wr_adr_i = 16'($urandom);
            cfg_len_i = 16'($urandom);
        end
        dreq_i = 1'b0;
        cfg_ld_i = 1'b0;
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL xfer_timeout: got %0d pending accesses busy=%0b, required completion",
                     exp_q.size(), busy_o);
        end
        @(negedge clk_i);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required self-termination");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int            d0, a0, s0, gaps, len;
        logic [AW-1:0] rd, wr;
        key = 16'($urandom);

        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst_cyc", 32'(wb.cyc_o), 32'd0);
        chk("rst_stb", 32'(wb.stb_o), 32'd0);
        chk("rst_we", 32'(wb.we_o), 32'd0);
        chk("rst_adr", 32'(wb.adr_o), 32'd0);
        chk("rst_dat", 32'(wb.dat_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        reset_i = 1'b0;

        // Single unit, ack one cycle after the strobe
        ack_lat = 1; stall_prob = 0; spurious = 0;
        cfg(16'h0100, 16'h0200, 16'd1);
        push_model(16'h0100, 16'h0200, 1);
        d0 = n_done;
        dreq_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("t1_cyc_latency", 32'(wb.cyc_o), 32'd1);
        chk("t1_stb_latency", 32'(wb.stb_o), 32'd1);
        chk("t1_first_adr", 32'(wb.adr_o), 32'h0100);
        run_xfer(0, 0, gaps);
        chk("t1_done", 32'(n_done - d0), 32'd1);
        chk("t1_cyc_low", 32'(wb.cyc_o), 32'd0);

        // Three back-to-back units with single-cycle acks
        ack_lat = 0;
        cfg(16'h0100, 16'h0200, 16'd3);
        push_model(16'h0100, 16'h0200, 3);
        d0 = n_done; a0 = n_acc;
        run_xfer(0, 0, gaps);
        chk("t2_accesses", 32'(n_acc - a0), 32'd6);
        chk("t2_cyc_gaps", 32'(gaps), 32'd0);
        chk("t2_done", 32'(n_done - d0), 32'd1);

        // Read strobe stalled three cycles
        ack_lat = 1; force_stall = 3;
        cfg(16'h0A00, 16'h0B00, 16'd1);
        push_model(16'h0A00, 16'h0B00, 1);
        a0 = n_acc; s0 = n_stall;
        run_xfer(0, 0, gaps);
        chk("t3_stall_cycles", 32'(n_stall - s0), 32'd3);
        chk("t3_accesses", 32'(n_acc - a0), 32'd2);

        // Address wrap at the top of the address space
        ack_lat = -1;
        cfg(16'hFFFF, 16'hFFFE, 16'd3);
        push_model(16'hFFFF, 16'hFFFE, 3);
        d0 = n_done;
        run_xfer(1, 0, gaps);
        chk("t4_done", 32'(n_done - d0), 32'd1);

        // Zero length: dreq must have no effect
        cfg(16'h1234, 16'h5678, 16'd0);
        a0 = n_acc;
        dreq_i = 1'b1;
        repeat (10) @(negedge clk_i);
        dreq_i = 1'b0;
        chk("len0_no_access", 32'(n_acc - a0), 32'd0);
        chk("len0_busy", 32'(busy_o), 32'd0);

        // Randomised transfers with stalls, variable latency, spurious acks and ignored cfg loads
        stall_prob = 30; ack_lat = -1; spurious = 1;
        for (int t = 0; t < 15; t++) begin
            rd = (t % 5 == 0) ? 16'hFFFD : 16'($urandom);
            wr = 16'($urandom);
            len = int'($urandom_range(1, 5));
            cfg(rd, wr, 16'(len));
            push_model(rd, wr, len);
            d0 = n_done;
            run_xfer(1, 1, gaps);
            chk("rand_done", 32'(n_done - d0), 32'd1);
        end

        // Reset while a write is outstanding
        stall_prob = 0; spurious = 0; ack_lat = 3;
        cfg(16'h0300, 16'h0400, 16'd3);
        push_model(16'h0300, 16'h0400, 3);
        dreq_i = 1'b1;
        begin
            bit hit;
            hit = 0;
            for (int i = 0; i < 100 && !hit; i++) begin
                @(negedge clk_i);
                if (wb.cyc_o && !wb.stb_o && wb.we_o) hit = 1;
            end
            chk("t5_reached_wr_wait", 32'(hit), 32'd1);
        end
        d0 = n_done;
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("t5_cyc", 32'(wb.cyc_o), 32'd0);
        chk("t5_stb", 32'(wb.stb_o), 32'd0);
        chk("t5_busy", 32'(busy_o), 32'd0);
        chk("t5_adr", 32'(wb.adr_o), 32'd0);
        chk("t5_dat", 32'(wb.dat_o), 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        exp_q.delete();
        a0 = n_acc;
        repeat (10) @(negedge clk_i);
        dreq_i = 1'b0;
        chk("t5_count_cleared", 32'(n_acc - a0), 32'd0);
        chk("t5_no_done", 32'(n_done - d0), 32'd0);
        chk("t5_idle_busy", 32'(busy_o), 32'd0);

        ack_lat = 1;
        cfg(16'h0050, 16'h0060, 16'd2);
        push_model(16'h0050, 16'h0060, 2);
        d0 = n_done;
        run_xfer(0, 0, gaps);
        chk("t5_recover_done", 32'(n_done - d0), 32'd1);

`ifdef WB_COPY_ERR_EN
        // Error on the read termination
        ack_lat = 1; inject_err = 1;
        cfg(16'h0500, 16'h0600, 16'd2);
        exp_q.push_back('{adr: 16'h0500, we: 1'b0, dat: 16'h0000});
        a0 = n_acc; d0 = n_done;
        dreq_i = 1'b1;
        for (int i = 0; i < 50 && !err_o; i++) @(negedge clk_i);
        chk("t6_err_set", 32'(err_o), 32'd1);
        repeat (10) @(negedge clk_i);
        chk("t6_cyc_low", 32'(wb.cyc_o), 32'd0);
        chk("t6_one_access", 32'(n_acc - a0), 32'd1);
        chk("t6_no_done", 32'(n_done - d0), 32'd0);
        chk("t6_busy", 32'(busy_o), 32'd0);
        dreq_i = 1'b0;
        cfg(16'h0700, 16'h0800, 16'd1);
        chk("t6_err_cleared", 32'(err_o), 32'd0);
        push_model(16'h0700, 16'h0800, 1);
        d0 = n_done;
        run_xfer(0, 0, gaps);
        chk("t6_recover_done", 32'(n_done - d0), 32'd1);
`endif

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
